// File: rtl/fault_code_pkg.sv
// Shared constants and helpers for the platform fault code scanner.
package fault_code_pkg;

  localparam int NUM_FAULTS_DEFAULT = 32;

  // Width of an index into an n-entry fault vector (never below one bit).
  function automatic int code_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Fault input bit positions for the platform power/management sources.
  localparam int FLT_BMC           = 0;
  localparam int FLT_PCH_P1V8      = 1;
  localparam int FLT_PCH_P1V05     = 2;
  localparam int FLT_PCH_PVNN      = 3;
  localparam int FLT_PSU_PWROK     = 4;
  localparam int FLT_PSU_ALERT     = 5;
  localparam int FLT_VR_P3V3_MAIN  = 6;
  localparam int FLT_VR_P5V_MAIN   = 7;
  localparam int FLT_VR_P12V_MAIN  = 8;
  localparam int FLT_CPU0_VCCIN    = 9;
  localparam int FLT_CPU0_VCCANA   = 10;
  localparam int FLT_CPU0_VDDQ_ABC = 11;
  localparam int FLT_CPU0_VDDQ_DEF = 12;
  localparam int FLT_CPU1_VCCIN    = 13;
  localparam int FLT_CPU1_VCCANA   = 14;
  localparam int FLT_CPU1_VDDQ_ABC = 15;
  localparam int FLT_CPU1_VDDQ_DEF = 16;

endpackage

// File: rtl/fault_next_find.sv
// Combinational round-robin finder: lowest set bit of vec strictly above
// pos, wrapping to the lowest set bit overall when nothing lies above.
module fault_next_find #(
  parameter int N = 32,
  parameter int W = 5
)(
  input  logic [N-1:0] vec,
  input  logic [W-1:0] pos,
  output logic         found,
  output logic [W-1:0] idx
);

  logic         above_hit;
  logic [W-1:0] above_idx;
  logic [W-1:0] low_idx;

  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    above_hit = 1'b0;
    above_idx = '0;
    found     = 1'b0;
    low_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found   = 1'b1;
        low_idx = W'(i);
        if (W'(i) > pos) begin
          above_hit = 1'b1;
          above_idx = W'(i);
        end
      end
    end
    idx = above_hit ? above_idx : low_idx;
  end

endmodule

// File: rtl/fault_code_scanner.sv
// Fault code scanner: cycles a display index through active faults on each
// scan strobe, records the first fault since reset/clear, and counts faults.
// Build option: define FAULT_STICKY_EN to latch fault bits until iClear.
module fault_code_scanner
  import fault_code_pkg::*;
#(
  parameter int NUM_FAULTS = NUM_FAULTS_DEFAULT,
  parameter int CODE_W     = code_w(NUM_FAULTS)
)(
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [NUM_FAULTS-1:0] iFault,
  input  logic                  iScanCE,
  input  logic [CODE_W-1:0]     iMaxIndex,
  input  logic                  iClear,
  output logic [CODE_W-1:0]     oFaultCode,
  output logic                  oFaultValid,
  output logic [CODE_W-1:0]     oFirstFault,
  output logic                  oFirstValid,
  output logic [CODE_W:0]       oFaultCount,
  output logic                  oMultiFault
);

  logic [NUM_FAULTS-1:0] idx_mask;
  logic [NUM_FAULTS-1:0] masked;
  logic [NUM_FAULTS-1:0] active;

  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [CODE_W-1:0] first_q;
  logic              first_valid_q;
  logic [CODE_W:0]   count_q;
  logic              multi_q;

  logic [CODE_W:0]   count_next;
  logic              scan_found;
  logic [CODE_W-1:0] scan_idx;
  logic              any_active;
  logic [CODE_W-1:0] lowest_idx;

  // Enable only indices 0..iMaxIndex.
  always_comb begin
    idx_mask = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      idx_mask[i] = (CODE_W'(i) <= iMaxIndex);
    end
  end

  assign masked = iFault & idx_mask;

`ifdef FAULT_STICKY_EN
  logic [NUM_FAULTS-1:0] latched_q;
  logic [NUM_FAULTS-1:0] latched_next;

  // A clear empties the latch in its own cycle, so a fault still present
  // re-enters one cycle later. Re-masking hides bits latched under a
  // higher iMaxIndex.
  assign latched_next = iClear ? '0 : (latched_q | masked);
  assign active       = latched_next & idx_mask;

  // Sticky fault latch.
  always_ff @(posedge iClk) begin
    if (!iRst_n) latched_q <= '0;
    else         latched_q <= latched_next;
  end
`else
  assign active = masked;
`endif

  fault_next_find #(
    .N (NUM_FAULTS),
    .W (CODE_W)
  ) u_scan_find (
    .vec   (active),
    .pos   (code_q),
    .found (scan_found),
    .idx   (scan_idx)
  );

  // With pos at its maximum nothing lies above it, so this returns the
  // lowest active index.
  fault_next_find #(
    .N (NUM_FAULTS),
    .W (CODE_W)
  ) u_low_find (
    .vec   (active),
    .pos   ({CODE_W{1'b1}}),
    .found (any_active),
    .idx   (lowest_idx)
  );

  // Population count of the active vector.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      count_next = count_next + (CODE_W+1)'(active[i]);
    end
  end

  // Display index: advances only on the scan strobe, otherwise holds.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else if (iScanCE) begin
      if (scan_found) begin
        code_q  <= scan_idx;
        valid_q <= 1'b1;
      end else begin
        code_q  <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  // First-fault record: captured while empty and any fault is active.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else if (iClear) begin
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else if (!first_valid_q && any_active) begin
      first_q       <= lowest_idx;
      first_valid_q <= 1'b1;
    end
  end

  // Fault count and multi-fault flag, registered every cycle.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      count_q <= '0;
      multi_q <= 1'b0;
    end else begin
      count_q <= count_next;
      multi_q <= (count_next > (CODE_W+1)'(1));
    end
  end

  assign oFaultCode  = code_q;
  assign oFaultValid = valid_q;
  assign oFirstFault = first_q;
  assign oFirstValid = first_valid_q;
  assign oFaultCount = count_q;
  assign oMultiFault = multi_q;

endmodule

// File: tb/tb_fault_code_scanner.sv
// Self-checking bench for fault_code_scanner (NUM_FAULTS=32).
module tb_fault_code_scanner;

  localparam int NF = 32;
  localparam int CW = 5;
`ifdef FAULT_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] fault;
  logic          scan;
  logic [CW-1:0] max_idx;
  logic          clear;
  logic [CW-1:0] code;
  logic          valid;
  logic [CW-1:0] first;
  logic          first_valid;
  logic [CW:0]   count;
  logic          multi;

  fault_code_scanner #(.NUM_FAULTS(NF), .CODE_W(CW)) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iFault      (fault),
    .iScanCE     (scan),
    .iMaxIndex   (max_idx),
    .iClear      (clear),
    .oFaultCode  (code),
    .oFaultValid (valid),
    .oFirstFault (first),
    .oFirstValid (first_valid),
    .oFaultCount (count),
    .oMultiFault (multi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NF-1:0] fault;
    logic          scan;
    logic [CW-1:0] maxi;
    int            code;
    int            valid;
    int            count;
    int            multi;
    int            first;
    int            fvalid;
  } vec_t;

  vec_t tbl[14];

  // Behavioural reference state for the random phase.
  int m_code, m_valid, m_count, m_multi, m_first, m_fv;
  bit m_lat[NF];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_code, input int e_valid,
                         input int e_count, input int e_multi,
                         input int e_first, input int e_fv);
    chk({tag, ".code"},   int'(code),        e_code);
    chk({tag, ".valid"},  int'(valid),       e_valid);
    chk({tag, ".count"},  int'(count),       e_count);
    chk({tag, ".multi"},  int'(multi),       e_multi);
    chk({tag, ".first"},  int'(first),       e_first);
    chk({tag, ".fvalid"}, int'(first_valid), e_fv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fault = '0; scan = 1'b0; clear = 1'b0; max_idx = 5'd31;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: next state from the rules, using a sorted list of
  // active indices.
  task automatic model_step();
    int act[$];
    bit new_lat[NF];
    if (!rst_n) begin
      m_code = 0; m_valid = 0; m_count = 0; m_multi = 0; m_first = 0; m_fv = 0;
      foreach (m_lat[i]) m_lat[i] = 1'b0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      bit in_range = (i <= int'(max_idx));
      bit on = in_range && !(STICKY && clear) && (fault[i] || (STICKY && m_lat[i]));
      if (on) act.push_back(i);
      new_lat[i] = STICKY && !clear && (m_lat[i] || (fault[i] && in_range));
    end
    if (scan) begin
      if (act.size() == 0) begin
        m_code = 0; m_valid = 0;
      end else begin
        int nxt = act[0];
        foreach (act[k]) begin
          if (act[k] > m_code) begin nxt = act[k]; break; end
        end
        m_code = nxt; m_valid = 1;
      end
    end
    if (clear) begin
      m_first = 0; m_fv = 0;
    end else if (m_fv == 0 && act.size() > 0) begin
      m_first = act[0]; m_fv = 1;
    end
    m_count = act.size();
    m_multi = (m_count > 1) ? 1 : 0;
    m_lat = new_lat;
  endtask

  initial begin
    logic [NF-1:0] f1, f2;
    f1 = (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 20);
    f2 = f1 | (32'h1 << 4) | (32'h1 << 12);

    //            fault scan max  code v cnt m first fv
    tbl[0]  = '{f1, 1'b0, 5'd31,  0, 0, 3, 1, 3, 1};
    tbl[1]  = '{f1, 1'b1, 5'd31,  3, 1, 3, 1, 3, 1};
    tbl[2]  = '{f1, 1'b1, 5'd31,  9, 1, 3, 1, 3, 1};
    tbl[3]  = '{f1, 1'b1, 5'd31, 20, 1, 3, 1, 3, 1};
    tbl[4]  = '{f1, 1'b1, 5'd31,  3, 1, 3, 1, 3, 1};
    tbl[5]  = '{f2, 1'b1, 5'd3,   3, 1, 1, 0, 3, 1};
    tbl[6]  = '{f2, 1'b1, 5'd3,   3, 1, 1, 0, 3, 1};
    tbl[7]  = '{f2, 1'b0, 5'd31,  3, 1, 5, 1, 3, 1};
    tbl[8]  = '{f2, 1'b1, 5'd31,  4, 1, 5, 1, 3, 1};
    tbl[9]  = '{f2, 1'b1, 5'd31,  9, 1, 5, 1, 3, 1};
    tbl[10] = '{f2, 1'b1, 5'd8,   3, 1, 2, 1, 3, 1};
    tbl[11] = '{f2, 1'b1, 5'd1,   0, 0, 0, 0, 3, 1};
    tbl[12] = '{f2, 1'b0, 5'd31,  0, 0, 5, 1, 3, 1};
    tbl[13] = '{f2, 1'b1, 5'd31,  3, 1, 5, 1, 3, 1};

    // Reset must dominate active inputs.
    rst_n = 1'b0; fault = f1; scan = 1'b1; clear = 1'b0; max_idx = 5'd31;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; fault = '0; scan = 1'b0;

    // Table vectors, applied back to back from reset.
    for (int v = 0; v < 14; v++) begin
      fault = tbl[v].fault; scan = tbl[v].scan; max_idx = tbl[v].maxi; clear = 1'b0;
      tick();
      chk_all($sformatf("tbl%0d", v), tbl[v].code, tbl[v].valid, tbl[v].count,
              tbl[v].multi, tbl[v].first, tbl[v].fvalid);
    end

    // First-fault capture and clear.
    do_reset();
    fault = 32'h1 << 5; tick();
    chk("ff.first5", int'(first), 5);
    chk("ff.valid5", int'(first_valid), 1);
    fault = (32'h1 << 5) | (32'h1 << 2); tick();
    chk("ff.hold5", int'(first), 5);
    fault = 32'h1 << 2; clear = 1'b1; tick();
    chk("ff.cleared", int'(first_valid), 0);
    clear = 1'b0; tick();
    chk("ff.first2", int'(first), 2);
    chk("ff.valid2", int'(first_valid), 1);

    // One-cycle pulse on bit 10: sticky keeps it on display until clear.
    do_reset();
    fault = 32'h1 << 10; scan = 1'b1; tick();
    chk("pulse.code", int'(code), 10);
    chk("pulse.valid", int'(valid), 1);
    fault = '0; scan = 1'b0; tick();
    chk("pulse.hold_code", int'(code), 10);
    chk("pulse.hold_valid", int'(valid), 1);
    for (int s = 0; s < 2; s++) begin
      scan = 1'b1; tick();
      chk($sformatf("pulse.strobe%0d_code", s), int'(code), STICKY ? 10 : 0);
      chk($sformatf("pulse.strobe%0d_valid", s), int'(valid), STICKY ? 1 : 0);
    end
    scan = 1'b0; clear = 1'b1; tick();
    chk("pulse.clr_holds_code", int'(code), STICKY ? 10 : 0);
    clear = 1'b0; scan = 1'b1; tick();
    chk("pulse.after_clr_code", int'(code), 0);
    chk("pulse.after_clr_valid", int'(valid), 0);
    scan = 1'b0;

    // Clear and new fault in the same cycle.
    do_reset();
    fault = 32'h1 << 1; clear = 1'b1; tick();
    chk("clrnew.count0", int'(count), STICKY ? 0 : 1);
    chk("clrnew.fvalid0", int'(first_valid), 0);
    clear = 1'b0; tick();
    chk("clrnew.count1", int'(count), 1);
    chk("clrnew.first", int'(first), 1);
    chk("clrnew.fvalid1", int'(first_valid), 1);

    // Reset mid-scan at code 20, then restart from the lowest active index.
    do_reset();
    fault = f1; scan = 1'b1;
    tick(); tick(); tick();
    chk("midrst.pre_code", int'(code), 20);
    rst_n = 1'b0; scan = 1'b0; tick();
    chk_all("midrst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; scan = 1'b1; tick();
    chk("midrst.post_code", int'(code), 3);
    chk("midrst.post_valid", int'(valid), 1);
    scan = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    model_step();
    rst_n = 1'b0; tick(); model_step_sync();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(199) != 0);
      if ($urandom_range(2) == 0) fault = fault ^ (32'h1 << $urandom_range(31));
      if ($urandom_range(15) == 0) fault = '0;
      scan  = ($urandom_range(2) == 0);
      clear = ($urandom_range(19) == 0);
      if ($urandom_range(29) == 0)
        max_idx = ($urandom_range(1) == 0) ? 5'd31 : 5'($urandom_range(31));
      model_step();
      tick();
      chk_all($sformatf("rand%0d", c), m_code, m_valid, m_count, m_multi, m_first, m_fv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bring the model to the reset state alongside the DUT.
  task automatic model_step_sync();
    model_step();
    rst_n = 1'b1;
  endtask

endmodule

// File: doc/fault_code_scanner.md
FAULT_CODE_SCANNER -- requirements
Module: fault_code_scanner

Interface
REQ-001 Parameter NUM_FAULTS, default 32: number of fault inputs monitored; legal range 2..256.
REQ-002 Parameter CODE_W, default $clog2(NUM_FAULTS): width of fault index outputs.
REQ-003 iClk  in  1  clock.
REQ-004 iRst_n  in  1  synchronous, active-low reset, sampled on rising iClk.
REQ-005 iFault  in  NUM_FAULTS  live fault flags; bit i high = source i faulted.
REQ-006 iScanCE  in  1  one-cycle display-advance strobe, e.g. 250 ms tick.
REQ-007 iMaxIndex  in  CODE_W  highest monitored index; bits above it are ignored.
REQ-008 iClear  in  1  one-cycle request to clear latched faults and first-fault record.
REQ-009 oFaultCode  out  CODE_W  index currently displayed.
REQ-010 oFaultValid  out  1  high when oFaultCode names an active fault.
REQ-011 oFirstFault  out  CODE_W  index of the first fault captured since reset/clear.
REQ-012 oFirstValid  out  1  oFirstFault holds a captured value.
REQ-013 oFaultCount  out  CODE_W+1  number of active faults.
REQ-014 oMultiFault  out  1  high when oFaultCount > 1.

Function
REQ-015 The active vector SHALL be iFault masked to indices 0..iMaxIndex; with FAULT_STICKY_EN it is the latched vector (REQ-027).
REQ-016 On iScanCE, the display SHALL advance to the lowest active index strictly greater than the current oFaultCode, wrapping to the lowest active index; outputs update on the cycle after the strobe.
REQ-017 Single active fault: oFaultCode SHALL stay on that index across strobes.
REQ-018 No active fault at a strobe: oFaultCode <= 0, oFaultValid <= 0.
REQ-019 Between strobes, oFaultCode SHALL hold even if its fault deasserts; oFaultValid drops on the next strobe.
REQ-020 First-fault capture: in the first cycle the active vector goes from zero to nonzero while oFirstValid=0, latch its lowest set index and set oFirstValid; hold until reset or iClear.
REQ-021 oFaultCount and oFaultCount-derived oMultiFault SHALL be registered every cycle: one-cycle latency from the active vector.
REQ-022 iClear and a new fault in the same cycle: clear wins; a still-asserted fault re-latches on the next cycle and is captured as first fault.
REQ-023 iClear SHALL not move oFaultCode; the next strobe applies REQ-016/018.
REQ-024 iMaxIndex lowered below oFaultCode: the next strobe wraps to the lowest active index at or below iMaxIndex.

Reset
REQ-025 While iRst_n=0 at a clock edge: oFaultCode=0, oFaultValid=0, oFirstFault=0, oFirstValid=0, oFaultCount=0, oMultiFault=0, latched vector=0.
REQ-026 Reset mid-scan SHALL discard all state; scanning restarts from index 0 on the first strobe after release.

Configuration
REQ-027 Macro FAULT_STICKY_EN defined: each active bit latches (latched |= masked iFault) and clears only on iClear or reset. Undefined: active vector is masked iFault live; iClear affects only the first-fault record.

Structure
REQ-028 Package fault_code_pkg SHALL hold the NUM_FAULTS default, the CODE_W function, and fault index localparams for platform sources (BMC, PCH rails, PSU, main VRs, CPU/VDDQ rails).
REQ-029 Sub-module fault_next_find SHALL be the combinational round-robin "next set index after position p, wrap" finder; the top holds all registers.

Verification
REQ-030 NUM_FAULTS=32, iMaxIndex=31, iFault bits 3,9,20 held; 4 strobes -> oFaultCode 3,9,20,3, oFaultValid=1, oFaultCount=3, oMultiFault=1.
REQ-031 iFault bit 5 then bit 2 one cycle later -> oFirstFault=5, oFirstValid=1; iClear -> oFirstValid=0; with bit 2 still high -> oFirstFault=2 next cycle.
REQ-032 iMaxIndex=7, iFault bits 4 and 12 -> strobes give 4,4; oFaultCount=1, oMultiFault=0.
REQ-033 FAULT_STICKY_EN: bit 10 pulsed one cycle -> oFaultCode=10 after strobe and remains for all strobes until iClear; without macro -> oFaultValid=0 at the following strobe.
REQ-034 iClear and iFault bit 1 rising in the same cycle (sticky) -> count 0 that cycle-plus-one, then count 1 and oFirstFault=1.
REQ-035 iRst_n low for 1 cycle mid-scan with code=20 -> all outputs 0; first strobe after release shows lowest active index.
